// File: rtl/mod_i2s_tx_ctrl.sv
// I2S transmit controller: one-entry sample holding register, SCK/WS/SD generation
// from the system clock, and frame scheduling with zero fill on underrun.
module mod_i2s_tx_ctrl #(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int SCK_HALF = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic                i_valid,
  input  logic [SAMPLE_W-1:0] i_left,
  input  logic [SAMPLE_W-1:0] i_right,
  output logic                o_ready,
  output logic                o_sck,
  output logic                o_ws,
  output logic                o_sd,
  output logic                o_frame_start,
  output logic                o_underrun
);

  localparam int P_W   = $clog2(2 * SLOT_W);
  localparam int DIV_W = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  localparam logic [P_W-1:0]   P_ONE    = P_W'(1);
  localparam logic [P_W-1:0]   P_SLOT   = P_W'(SLOT_W);
  localparam logic [P_W-1:0]   P_LAST   = P_W'(2 * SLOT_W - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_HALF - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state_r, state_s;

  logic                hold_full_r, hold_full_s;
  logic [SAMPLE_W-1:0] hold_left_r, hold_left_s;
  logic [SAMPLE_W-1:0] hold_right_r, hold_right_s;
  logic [SAMPLE_W-1:0] frame_left_r, frame_left_s;
  logic [SAMPLE_W-1:0] frame_right_r, frame_right_s;
  logic [DIV_W-1:0]    div_r, div_s;
  logic [P_W-1:0]      p_r, p_s;
  logic                sck_r, sck_s;
  logic                ws_r, ws_s;
  logic                sd_r, sd_s;
  logic                ready_r, ready_s;
  logic                frame_start_r, frame_start_s;
  logic                underrun_r, underrun_s;
  logic                tick_s, load_s, xfer_s;

  // Bit carried at position p: MSB-first sample after a one-bit delay, zero padded.
  function automatic logic sd_bit(input logic [P_W-1:0]      p,
                                  input logic [SAMPLE_W-1:0] l,
                                  input logic [SAMPLE_W-1:0] r);
    logic [SAMPLE_W-1:0] sh;
    if (p == '0) begin
      sh = '0;
    end else if (p <= P_SLOT) begin
      sh = l << (p - P_ONE);
    end else begin
      sh = r << (p - P_SLOT - P_ONE);
    end
    return sh[SAMPLE_W-1];
  endfunction

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: enable alone decides between IDLE and RUN
  always_comb begin
    state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: state_s = i_enable ? ST_RUN : ST_IDLE;
      ST_RUN:  state_s = i_enable ? ST_RUN : ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Next values for divider, bit position, holding/frame registers and outputs
  always_comb begin
    hold_full_s   = hold_full_r;
    hold_left_s   = hold_left_r;
    hold_right_s  = hold_right_r;
    frame_left_s  = frame_left_r;
    frame_right_s = frame_right_r;
    div_s         = div_r;
    p_s           = p_r;
    sck_s         = sck_r;
    ws_s          = ws_r;
    sd_s          = sd_r;
    frame_start_s = 1'b0;
    underrun_s    = 1'b0;
    tick_s        = 1'b0;
    load_s        = 1'b0;
    xfer_s        = i_valid & ready_r;

    if (state_s == ST_IDLE) begin
      hold_full_s = 1'b0;
      div_s       = '0;
      p_s         = '0;
      sck_s       = 1'b0;
      ws_s        = 1'b0;
      sd_s        = 1'b0;
    end else if (state_r == ST_IDLE) begin
      // RUN entry: fresh frame at p=0, the holding register is empty here
      hold_full_s = 1'b0;
      div_s       = '0;
      p_s         = '0;
      sck_s       = 1'b0;
      ws_s        = 1'b0;
      sd_s        = 1'b0;
      load_s      = 1'b1;
    end else begin
      if (div_r == DIV_LAST) begin
        div_s  = '0;
        sck_s  = ~sck_r;
        tick_s = sck_r;
      end else begin
        div_s  = div_r + DIV_ONE;
      end

      if (tick_s) begin
        p_s    = (p_r == P_LAST) ? '0 : p_r + P_ONE;
        ws_s   = (p_s >= P_SLOT);
        sd_s   = sd_bit(p_s, frame_left_r, frame_right_r);
        load_s = (p_r == P_LAST);
      end else begin
        load_s = 1'b0;
      end

      // No bypass: a pair accepted on the load cycle waits for the next frame
      if (xfer_s) begin
        hold_full_s  = 1'b1;
        hold_left_s  = i_left;
        hold_right_s = i_right;
      end else if (load_s && hold_full_r) begin
        hold_full_s  = 1'b0;
      end else begin
        hold_full_s  = hold_full_r;
      end
    end

    if (load_s) begin
      frame_start_s = 1'b1;
      if (hold_full_r) begin
        frame_left_s  = hold_left_r;
        frame_right_s = hold_right_r;
        underrun_s    = 1'b0;
      end else begin
        frame_left_s  = '0;
        frame_right_s = '0;
        underrun_s    = 1'b1;
      end
    end else begin
      frame_start_s = 1'b0;
      underrun_s    = 1'b0;
    end

    ready_s = (state_s == ST_RUN) & ~hold_full_s;
  end

  // Datapath and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold_full_r   <= 1'b0;
      hold_left_r   <= '0;
      hold_right_r  <= '0;
      frame_left_r  <= '0;
      frame_right_r <= '0;
      div_r         <= '0;
      p_r           <= '0;
      sck_r         <= 1'b0;
      ws_r          <= 1'b0;
      sd_r          <= 1'b0;
      ready_r       <= 1'b0;
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
    end else begin
      hold_full_r   <= hold_full_s;
      hold_left_r   <= hold_left_s;
      hold_right_r  <= hold_right_s;
      frame_left_r  <= frame_left_s;
      frame_right_r <= frame_right_s;
      div_r         <= div_s;
      p_r           <= p_s;
      sck_r         <= sck_s;
      ws_r          <= ws_s;
      sd_r          <= sd_s;
      ready_r       <= ready_s;
      frame_start_r <= frame_start_s;
      underrun_r    <= underrun_s;
    end
  end

  assign o_ready       = ready_r;
  assign o_sck         = sck_r;
  assign o_ws          = ws_r;
  assign o_sd          = sd_r;
  assign o_frame_start = frame_start_r;
  assign o_underrun    = underrun_r;

endmodule

// File: tb/tb_mod_i2s_tx_ctrl.sv
// Directed bench for mod_i2s_tx_ctrl at default parameters (1024-cycle frames).
module tb_mod_i2s_tx_ctrl;

  logic        clk, rst, en, valid;
  logic [15:0] left, right;
  logic        ready, sck, ws, sd, fs, ur;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [63:0] sdv, wsv;
  logic [31:0] sckv;
  int          fsc, xf, rc;
  logic        sd15, sd16;

  mod_i2s_tx_ctrl #(.SAMPLE_W(16), .SLOT_W(32), .SCK_HALF(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_valid(valid),
    .i_left(left), .i_right(right), .o_ready(ready), .o_sck(sck),
    .o_ws(ws), .o_sd(sd), .o_frame_start(fs), .o_underrun(ur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one frame from its load cycle to the next load cycle.
  // mode 0: idle, 1: one valid pulse at send_at, 2: valid held (dropped at k=1023), 3: valid only at k=1023
  task automatic run_frame(input int mode, input int send_at,
                           input logic [15:0] l, input logic [15:0] r);
    sdv = '0; wsv = '0; sckv = '0; fsc = 0; xf = 0; rc = 0; sd15 = 1'b0; sd16 = 1'b0;
    for (int k = 0; k < 1024; k++) begin
      if (k % 16 == 8) begin
        sdv[63 - k / 16] = sd;
        wsv[63 - k / 16] = ws;
      end
      if (k < 16) sckv[31 - k] = sck;
      if (k >= 1008) sckv[15 - (k - 1008)] = sck;
      if (k == 15) sd15 = sd;
      if (k == 16) sd16 = sd;
      if (k > 0 && fs) fsc++;
      if (ready) rc++;
      case (mode)
        1:       valid = (k == send_at);
        2:       valid = (k != 1023);
        3:       valid = (k == 1023);
        default: valid = 1'b0;
      endcase
      left = l;
      right = r;
      if (valid && ready) xf++;
      step();
    end
    valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; valid = 1'b0; left = '0; right = '0;
    #1 rst = 1'b1;
    step(); step();
    chk("reset_outputs", {sck, ws, sd, ready, fs, ur}, 6'b000000);
    rst = 1'b0;
    step(); step();
    chk("idle_outputs", {sck, ws, sd, ready, fs, ur}, 6'b000000);

    en = 1'b1;
    step();
    chk("entry_pulses", {fs, ur, ready, sck, ws, sd}, 6'b111000);

    // Frame 0: underrun frame, pair A5C3/8001 accepted mid-frame
    run_frame(1, 100, 16'hA5C3, 16'h8001);
    chk("f0_sd", sdv, 64'h0);
    chk("f0_ws", wsv, 64'h0000_0000_FFFF_FFFF);
    chk("f0_sck", sckv, 32'h00FF_00FF);
    chk("f0_fs_count", fsc, 64'd0);
    chk("f0_xfers", xf, 64'd1);
    chk("f1_load", {fs, ur, ready}, 3'b101);

    run_frame(0, 0, 16'h0000, 16'h0000);
    chk("f1_sd", sdv, {1'b0, 16'hA5C3, 16'h0000, 16'h8001, 15'h0000});
    chk("f1_ws", wsv, 64'h0000_0000_FFFF_FFFF);
    chk("f1_msb_timing", {sd15, sd16}, 2'b01);
    chk("f2_load", {fs, ur, ready}, 3'b111);

    // Back-to-back pairs with valid held high
    run_frame(2, 0, 16'h1234, 16'h5678);
    chk("f2_sd", sdv, 64'h0);
    chk("f2_xfers", xf, 64'd1);
    chk("f2_ready_cycles", rc, 64'd1);
    chk("f3_load", {fs, ur}, 2'b10);

    run_frame(2, 0, 16'hF00F, 16'h0FF0);
    chk("f3_sd", sdv, {1'b0, 16'h1234, 16'h0000, 16'h5678, 15'h0000});
    chk("f3_xfers", xf, 64'd1);
    chk("f3_ready_cycles", rc, 64'd1);
    chk("f4_load", {fs, ur}, 2'b10);

    // Transfer coincides with the load while holding is empty: underrun, no bypass
    run_frame(3, 0, 16'h8000, 16'h0001);
    chk("f4_sd", sdv, {1'b0, 16'hF00F, 16'h0000, 16'h0FF0, 15'h0000});
    chk("f4_xfers", xf, 64'd1);
    chk("f5_load_underrun", {fs, ur, ready}, 3'b110);

    run_frame(0, 0, 16'h0000, 16'h0000);
    chk("f5_sd", sdv, 64'h0);
    chk("f5_ready_cycles", rc, 64'd0);
    chk("f6_load", {fs, ur, ready}, 3'b101);

    run_frame(0, 0, 16'h0000, 16'h0000);
    chk("f6_sd", sdv, {1'b0, 16'h8000, 16'h0000, 16'h0001, 15'h0000});
    chk("f7_load", {fs, ur, ready}, 3'b111);

    // Fill holding, then drop enable at p=20 with SCK high
    valid = 1'b1; left = 16'hDEAD; right = 16'hBEEF;
    step();
    valid = 1'b0;
    chk("held_full", ready, 1'b0);
    repeat (327) step();
    chk("p20_sck_high", sck, 1'b1);
    en = 1'b0;
    step();
    chk("disable_outputs", {sck, ws, sd, ready, fs, ur}, 6'b000000);
    repeat (3) step();
    en = 1'b1;
    step();
    chk("reenable_entry", {fs, ur, ready}, 3'b111);

    run_frame(0, 0, 16'h0000, 16'h0000);
    chk("reenable_sd", sdv, 64'h0);
    chk("reenable_ws", wsv, 64'h0000_0000_FFFF_FFFF);
    chk("reenable_next_load", {fs, ur}, 2'b11);

    // Asynchronous reset mid-frame
    repeat (408) step();
    chk("pre_reset_state", {sck, ready}, 2'b11);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", {sck, ws, sd, ready, fs, ur}, 6'b000000);
    step();
    chk("reset_held", {sck, ws, sd, ready, fs, ur}, 6'b000000);
    rst = 1'b0;
    step();
    chk("entry_after_reset", {fs, ur, ready}, 3'b111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
